// File: rtl/warp_scheduler_if.sv
// Issue port between the warp scheduler and the execution pipeline:
// valid/ready handshake plus the selected warp's instruction fields.
interface warp_scheduler_if #(
  parameter int WARP_W = 2
);
  logic              issue_valid;
  logic              issue_ready;
  logic [WARP_W-1:0] issue_warp;
  logic [3:0]        issue_opcode;
  logic [3:0]        issue_target_reg;
  logic [3:0]        issue_address_reg;
  logic [3:0]        issue_imm_short;
  logic [1:0]        issue_array_id;

  modport master (
    output issue_valid, issue_warp, issue_opcode, issue_target_reg,
           issue_address_reg, issue_imm_short, issue_array_id,
    input  issue_ready
  );

  modport slave (
    input  issue_valid, issue_warp, issue_opcode, issue_target_reg,
           issue_address_reg, issue_imm_short, issue_array_id,
    output issue_ready
  );
endinterface

// File: rtl/warp_scheduler.sv
// Per-warp instruction-buffer sequencer: round-robin refill requests toward
// fetch and round-robin, lockable issue arbitration toward the pipeline.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | buffer entry free, waiting for a refill slot
// ST_FETCH | refill requested, waiting for the buffer write (only one)
// ST_READY | instruction buffered, eligible for issue while active
// ST_WAIT  | long-latency op in flight, waiting for writeback
// ST_DONE  | halt issued; terminal until reset
module warp_scheduler #(
  parameter int         NUM_WARPS = 4,
  parameter int         WARP_W    = 2,
  parameter logic [3:0] HALT_OP   = 4'hF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_WARPS-1:0]   warp_active,
  output logic                   fetch_req,
  output logic [WARP_W-1:0]      fetch_warp,
  input  logic                   fill_valid,
  input  logic [WARP_W-1:0]      fill_warp,
  input  logic [4*NUM_WARPS-1:0] opcode_in,
  input  logic [4*NUM_WARPS-1:0] target_reg_in,
  input  logic [4*NUM_WARPS-1:0] address_reg_in,
  input  logic [4*NUM_WARPS-1:0] imm_short_in,
  input  logic [2*NUM_WARPS-1:0] array_id_in,
  warp_scheduler_if.master       issue,
  input  logic                   wb_done,
  input  logic [WARP_W-1:0]      wb_warp,
  output logic [NUM_WARPS-1:0]   warp_done,
  output logic                   all_done
);

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_FETCH = 3'd1,
    ST_READY = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } warp_state_t;

  warp_state_t       state_q [NUM_WARPS];
  logic [WARP_W-1:0] fetch_ptr_q, issue_ptr_q, lock_warp_q, fetch_warp_q;
  logic              fetch_busy_q, lock_q, all_done_q;

  logic [3:0] op_arr [NUM_WARPS];
  logic [3:0] tr_arr [NUM_WARPS];
  logic [3:0] ar_arr [NUM_WARPS];
  logic [3:0] imm_arr[NUM_WARPS];
  logic [1:0] aid_arr[NUM_WARPS];

  logic [NUM_WARPS-1:0] empty_elig, ready_elig, done_vec, done_next;
  logic [WARP_W:0]      fetch_pick, issue_pick;
  logic [WARP_W-1:0]    issue_sel;
  logic                 issue_vld, issue_fire;
  logic [3:0]           sel_op;

  // First requester at or after ptr, with wrap; MSB flags a hit.
  function automatic logic [WARP_W:0] rr_pick(input logic [NUM_WARPS-1:0] req,
                                              input logic [WARP_W-1:0]    ptr);
    int idx;
    rr_pick = '0;
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_WARPS;
      if (req[idx]) rr_pick = {1'b1, WARP_W'(idx)};
    end
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      op_arr[i]     = opcode_in[4*i +: 4];
      tr_arr[i]     = target_reg_in[4*i +: 4];
      ar_arr[i]     = address_reg_in[4*i +: 4];
      imm_arr[i]    = imm_short_in[4*i +: 4];
      aid_arr[i]    = array_id_in[2*i +: 2];
      empty_elig[i] = (state_q[i] == ST_EMPTY) && warp_active[i];
      ready_elig[i] = (state_q[i] == ST_READY) && warp_active[i];
      done_vec[i]   = (state_q[i] == ST_DONE);
    end
  end

  assign fetch_pick = rr_pick(empty_elig, fetch_ptr_q);
  assign issue_pick = rr_pick(ready_elig, issue_ptr_q);

  // A locked grant survives its warp going inactive or losing priority.
  assign issue_sel  = lock_q ? lock_warp_q : issue_pick[WARP_W-1:0];
  assign issue_vld  = lock_q | issue_pick[WARP_W];
  assign issue_fire = issue_vld & issue.issue_ready;
  assign sel_op     = op_arr[issue_sel];

  always_comb begin
    done_next = done_vec;
    if (issue_fire && sel_op == HALT_OP) done_next[issue_sel] = 1'b1;
  end

  assign issue.issue_valid       = issue_vld;
  assign issue.issue_warp        = issue_vld ? issue_sel : '0;
  assign issue.issue_opcode      = issue_vld ? sel_op : '0;
  assign issue.issue_target_reg  = issue_vld ? tr_arr[issue_sel] : '0;
  assign issue.issue_address_reg = issue_vld ? ar_arr[issue_sel] : '0;
  assign issue.issue_imm_short   = issue_vld ? imm_arr[issue_sel] : '0;
  assign issue.issue_array_id    = issue_vld ? aid_arr[issue_sel] : '0;

  assign fetch_req  = fetch_busy_q;
  assign fetch_warp = fetch_warp_q;
  assign warp_done  = done_vec;
  assign all_done   = all_done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WARPS; i++) state_q[i] <= ST_EMPTY;
      fetch_ptr_q  <= '0;
      issue_ptr_q  <= '0;
      lock_warp_q  <= '0;
      fetch_warp_q <= '0;
      fetch_busy_q <= 1'b0;
      lock_q       <= 1'b0;
      all_done_q   <= 1'b0;
    end else begin
      if (fetch_busy_q) begin
        if (fill_valid && fill_warp == fetch_warp_q) begin
          state_q[fetch_warp_q] <= ST_READY;
          fetch_busy_q          <= 1'b0;
          fetch_warp_q          <= '0;
        end
      end else if (fetch_pick[WARP_W]) begin
        state_q[fetch_pick[WARP_W-1:0]] <= ST_FETCH;
        fetch_busy_q <= 1'b1;
        fetch_warp_q <= fetch_pick[WARP_W-1:0];
        fetch_ptr_q  <= WARP_W'((int'(fetch_pick[WARP_W-1:0]) + 1) % NUM_WARPS);
      end

      if (issue_fire) begin
        if (sel_op == HALT_OP)  state_q[issue_sel] <= ST_DONE;
        else if (sel_op[3])     state_q[issue_sel] <= ST_WAIT;
        else                    state_q[issue_sel] <= ST_EMPTY;
        issue_ptr_q <= WARP_W'((int'(issue_sel) + 1) % NUM_WARPS);
        lock_q      <= 1'b0;
      end else if (issue_vld) begin
        lock_q      <= 1'b1;
        lock_warp_q <= issue_sel;
      end

      if (wb_done && state_q[wb_warp] == ST_WAIT) state_q[wb_warp] <= ST_EMPTY;

      all_done_q <= (|warp_active) && (&(done_next | ~warp_active));
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Randomized bench for warp_scheduler against a cycle-level reference model
// of the warp lifecycle, fetch round-robin and issue lock rules.
module tb_warp_scheduler;
  localparam int NW = 4;
  localparam int S_E = 0, S_F = 1, S_R = 2, S_W = 3, S_D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NW-1:0] warp_active;
  logic          fetch_req;
  logic [1:0]    fetch_warp;
  logic          fill_valid;
  logic [1:0]    fill_warp;
  logic [4*NW-1:0] opcode_in, target_reg_in, address_reg_in, imm_short_in;
  logic [2*NW-1:0] array_id_in;
  logic          wb_done;
  logic [1:0]    wb_warp;
  logic [NW-1:0] warp_done;
  logic          all_done;

  warp_scheduler_if #(.WARP_W(2)) issue_if ();

  warp_scheduler dut (
    .clk(clk), .reset(reset), .warp_active(warp_active),
    .fetch_req(fetch_req), .fetch_warp(fetch_warp),
    .fill_valid(fill_valid), .fill_warp(fill_warp),
    .opcode_in(opcode_in), .target_reg_in(target_reg_in),
    .address_reg_in(address_reg_in), .imm_short_in(imm_short_in),
    .array_id_in(array_id_in), .issue(issue_if.master),
    .wb_done(wb_done), .wb_warp(wb_warp),
    .warp_done(warp_done), .all_done(all_done)
  );

  always #5 clk = ~clk;

  logic [3:0] b_op[NW], b_tr[NW], b_ar[NW], b_imm[NW];
  logic [1:0] b_aid[NW];

  always_comb begin
    for (int i = 0; i < NW; i++) begin
      opcode_in[4*i +: 4]      = b_op[i];
      target_reg_in[4*i +: 4]  = b_tr[i];
      address_reg_in[4*i +: 4] = b_ar[i];
      imm_short_in[4*i +: 4]   = b_imm[i];
      array_id_in[2*i +: 2]    = b_aid[i];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  int m_st[NW];
  int m_fptr, m_iptr, m_lock, m_lock_w, m_all_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) m_st[i] = S_E;
    m_fptr = 0; m_iptr = 0; m_lock = 0; m_lock_w = 0; m_all_done = 0;
  endtask

  function automatic logic [3:0] rand_op(input int halt_pct, input int long_pct);
    int r;
    r = $urandom_range(99);
    if (r < halt_pct) return 4'hF;
    if (r < halt_pct + long_pct) return 4'(8 + $urandom_range(6));
    return 4'($urandom_range(7));
  endfunction

  // Called at a negedge; drives, checks, advances the model across the next posedge.
  task automatic run_cycles(input int n, input int p_fill, input int p_rdy, input int p_wb,
                            input int halt_pct, input int long_pct, input int p_act);
    int ost[NW];
    int fw, v, sel, w, alld;
    int wl[$];
    logic [17:0] exp_pay;
    logic [NW-1:0] exp_done;
    for (int c = 0; c < n; c++) begin
      fw = -1;
      for (int i = 0; i < NW; i++) if (m_st[i] == S_F) fw = i;
      if (fw >= 0 && int'($urandom_range(99)) < p_fill) begin
        fill_valid = 1'b1; fill_warp = 2'(fw);
        b_op[fw] = rand_op(halt_pct, long_pct);
        b_tr[fw] = 4'($urandom); b_ar[fw] = 4'($urandom);
        b_imm[fw] = 4'($urandom); b_aid[fw] = 2'($urandom);
      end else begin
        fill_valid = ($urandom_range(99) < 5);
        fill_warp  = 2'($urandom);
      end
      issue_if.issue_ready = (int'($urandom_range(99)) < p_rdy);
      wl.delete();
      for (int i = 0; i < NW; i++) if (m_st[i] == S_W) wl.push_back(i);
      if (wl.size() > 0 && int'($urandom_range(99)) < p_wb) begin
        wb_done = 1'b1; wb_warp = 2'(wl[$urandom_range(wl.size() - 1)]);
      end else begin
        wb_done = ($urandom_range(99) < 5);
        wb_warp = 2'($urandom);
      end
      if (int'($urandom_range(99)) < p_act) warp_active = 4'($urandom);
      #1;

      v = 0; sel = 0;
      if (m_lock != 0) begin
        v = 1; sel = m_lock_w;
      end else begin
        for (int k = 0; k < NW; k++) begin
          w = (m_iptr + k) % NW;
          if (v == 0 && m_st[w] == S_R && warp_active[w]) begin v = 1; sel = w; end
        end
      end
      exp_pay = (v != 0) ? {b_op[sel], b_tr[sel], b_ar[sel], b_imm[sel], b_aid[sel]} : 18'd0;
      for (int i = 0; i < NW; i++) exp_done[i] = (m_st[i] == S_D);
      check("fetch_req", 32'(fetch_req), 32'(fw >= 0));
      check("fetch_warp", 32'(fetch_warp), 32'((fw >= 0) ? fw : 0));
      check("issue_valid", 32'(issue_if.issue_valid), 32'(v));
      check("issue_warp", 32'(issue_if.issue_warp), 32'(sel));
      check("issue_payload", 32'({issue_if.issue_opcode, issue_if.issue_target_reg,
            issue_if.issue_address_reg, issue_if.issue_imm_short, issue_if.issue_array_id}),
            32'(exp_pay));
      check("warp_done", 32'(warp_done), 32'(exp_done));
      check("all_done", 32'(all_done), 32'(m_all_done));

      ost = m_st;
      if (fill_valid && ost[fill_warp] == S_F) m_st[fill_warp] = S_R;
      if (v != 0 && issue_if.issue_ready) begin
        if (b_op[sel] == 4'hF) m_st[sel] = S_D;
        else if (b_op[sel][3]) m_st[sel] = S_W;
        else                   m_st[sel] = S_E;
        m_iptr = (sel + 1) % NW;
        m_lock = 0;
      end else if (v != 0) begin
        m_lock = 1; m_lock_w = sel;
      end
      if (wb_done && ost[wb_warp] == S_W) m_st[wb_warp] = S_E;
      if (fw < 0) begin
        for (int k = NW - 1; k >= 0; k--) begin
          w = (m_fptr + k) % NW;
          if (ost[w] == S_E && warp_active[w]) fw = w;
        end
        if (fw >= 0) begin
          m_st[fw] = S_F;
          m_fptr = (fw + 1) % NW;
        end
      end
      alld = (warp_active != 0) ? 1 : 0;
      for (int i = 0; i < NW; i++) if (warp_active[i] && m_st[i] != S_D) alld = 0;
      m_all_done = alld;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fetch_req"}, 32'(fetch_req), 32'd0);
    check({tag, "_fetch_warp"}, 32'(fetch_warp), 32'd0);
    check({tag, "_issue_valid"}, 32'(issue_if.issue_valid), 32'd0);
    check({tag, "_issue_warp"}, 32'(issue_if.issue_warp), 32'd0);
    check({tag, "_warp_done"}, 32'(warp_done), 32'd0);
    check({tag, "_all_done"}, 32'(all_done), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    warp_active = 4'b1111;
    fill_valid = 1'b0; fill_warp = 2'd0;
    wb_done = 1'b0; wb_warp = 2'd0;
    issue_if.issue_ready = 1'b0;
    for (int i = 0; i < NW; i++) begin
      b_op[i] = 4'h0; b_tr[i] = 4'h0; b_ar[i] = 4'h0; b_imm[i] = 4'h0; b_aid[i] = 2'd0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;

    // Clean streaming: every fetch filled, pipeline always ready, short ops only.
    run_cycles(40, 100, 100, 100, 0, 0, 0);
    // Mixed traffic with long-latency ops, stray fills/writebacks and mask changes.
    run_cycles(700, 60, 60, 40, 2, 30, 3);
    warp_active = 4'b1111;
    // Back-pressure heavy: exercises the issue lock.
    run_cycles(150, 80, 15, 30, 0, 40, 0);

    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    fill_valid = 1'b0; wb_done = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    warp_active = 4'b1111;
    run_cycles(60, 70, 70, 50, 0, 40, 0);

    // Halt-heavy: every warp retires.
    run_cycles(300, 90, 90, 80, 60, 20, 0);
    check("final_all_done", 32'(all_done), 32'd1);
    check("final_fetch_idle", 32'(fetch_req), 32'd0);
    check("final_warp_done", 32'(warp_done), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
